// File: rtl/down_counter_tc_if.sv
// Control and status bundle for down_counter_tc.
// master drives the controls and observes the counter; slave is the counter itself.
interface down_counter_tc_if #(
    parameter int WIDTH = 4,
    parameter int WRAPW = 8
);
    logic             start;
    logic             en;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] cnt;
    logic             cnt_tc;
    logic             tc_pulse;
    logic [WRAPW-1:0] wraps;

    modport master (
        output start, en, ld, ld_val,
        input  cnt, cnt_tc, tc_pulse, wraps
    );

    modport slave (
        input  start, en, ld, ld_val,
        output cnt, cnt_tc, tc_pulse, wraps
    );
endinterface

// File: rtl/down_counter_tc.sv
// Loadable down-counter with a zero detect, a one-cycle reach-zero pulse and a
// saturating count of zero -> all-ones wraps. Priority per edge: rst > ld > decrement > hold.
module down_counter_tc #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter int WRAPW     = 8
) (
    input logic              ck,
    input logic              rst,
    down_counter_tc_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_CNT = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic [WRAPW-1:0] wraps_q, wraps_d;
    logic             is_zero;
    logic             dec;

    always_comb begin
        is_zero    = (cnt_q == '0);
        dec        = bus.en & (bus.start | ~is_zero);
        cnt_d      = cnt_q;
        tc_pulse_d = 1'b0;
        wraps_d    = wraps_q;
        if (bus.ld) begin
            cnt_d = bus.ld_val;
        end else if (dec) begin
            cnt_d      = cnt_q - ONE;
            tc_pulse_d = (cnt_q == ONE);
            // Decrementing from zero is the wrap; the tally sticks at all-ones.
            if (is_zero && (wraps_q != '1)) begin
                wraps_d = wraps_q + WRAPW'(1);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt_q      <= RST_CNT;
            tc_pulse_q <= 1'b0;
            wraps_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tc_pulse_q <= tc_pulse_d;
            wraps_q    <= wraps_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.cnt_tc   = is_zero;
    assign bus.tc_pulse = tc_pulse_q;
    assign bus.wraps    = wraps_q;
endmodule

// File: tb/tb_down_counter_tc.sv
// Bench for down_counter_tc: a vector table, directed corner sequences and random
// stimulus against a reference model; a WRAPW=2 copy shares the stimulus for saturation.
module tb_down_counter_tc;
    localparam int W    = 4;
    localparam int MAXC = (1 << W) - 1;

    logic         ck;
    logic         rst, start, en, ld;
    logic [W-1:0] ld_val;

    int tests_run = 0;
    int tests_failed = 0;

    down_counter_tc_if #(.WIDTH(W), .WRAPW(8)) bus_m ();
    down_counter_tc_if #(.WIDTH(W), .WRAPW(2)) bus_s ();

    assign bus_m.start = start;  assign bus_s.start = start;
    assign bus_m.en = en;        assign bus_s.en = en;
    assign bus_m.ld = ld;        assign bus_s.ld = ld;
    assign bus_m.ld_val = ld_val; assign bus_s.ld_val = ld_val;

    down_counter_tc #(.WIDTH(W), .RESET_VAL(0), .WRAPW(8)) dut (
        .ck(ck), .rst(rst), .bus(bus_m)
    );
    down_counter_tc #(.WIDTH(W), .RESET_VAL(0), .WRAPW(2)) dut_sat (
        .ck(ck), .rst(rst), .bus(bus_s)
    );

    // clock / reset block
    initial ck = 1'b0;
    always #5 ck = ~ck;

    // reference model: the count as a plain integer
    int m_cnt, m_pulse, m_wraps, m_wraps_sat;
    bit m_valid = 0;

    task automatic model_edge();
        if (rst) begin
            m_cnt = 0; m_pulse = 0; m_wraps = 0; m_wraps_sat = 0; m_valid = 1;
        end else if (ld) begin
            m_cnt = int'(ld_val); m_pulse = 0;
        end else if (en && (start || m_cnt != 0)) begin
            m_pulse = (m_cnt == 1) ? 1 : 0;
            if (m_cnt == 0) begin
                m_cnt       = MAXC;
                m_wraps     = (m_wraps + 1 > 255) ? 255 : m_wraps + 1;
                m_wraps_sat = (m_wraps_sat + 1 > 3) ? 3 : m_wraps_sat + 1;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        if (m_valid) begin
            check("m_cnt", 32'(bus_m.cnt), 32'(m_cnt));
            check("m_tc", 32'(bus_m.cnt_tc), (m_cnt == 0) ? 32'd1 : 32'd0);
            check("m_pulse", 32'(bus_m.tc_pulse), 32'(m_pulse));
            check("m_wraps", 32'(bus_m.wraps), 32'(m_wraps));
            check("m_wraps_sat", 32'(bus_s.wraps), 32'(m_wraps_sat));
        end
    endtask

    // driver: one rising edge with the currently driven inputs
    task automatic tick();
        @(posedge ck);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input int r, input int l, input int e, input int s, input int v);
        rst = r[0]; ld = l[0]; en = e[0]; start = s[0]; ld_val = v[W-1:0];
    endtask

    typedef struct {
        logic         rst, ld, en, start;
        logic [W-1:0] ld_val;
        logic [W-1:0] cnt;
        logic         tc, pulse;
    } vec_t;

    function automatic vec_t mk(input int r, input int l, input int e, input int s,
                                input int v, input int c, input int t, input int p);
        vec_t x;
        x.rst = r[0]; x.ld = l[0]; x.en = e[0]; x.start = s[0];
        x.ld_val = v[W-1:0]; x.cnt = c[W-1:0]; x.tc = t[0]; x.pulse = p[0];
        return x;
    endfunction

    vec_t vecs[18];
    int r0, r1, pulses;

    initial begin
        drive(1, 0, 0, 0, 0);

        //            rst ld en st val  cnt tc p
        vecs[0]  = mk(1, 0, 0, 0, 0,    0, 1, 0);
        vecs[1]  = mk(0, 1, 0, 0, 10,  10, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0,    9, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0,    8, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0,    8, 0, 0);
        vecs[5]  = mk(0, 0, 1, 1, 0,    7, 0, 0);
        vecs[6]  = mk(0, 1, 1, 0, 2,    2, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0,    1, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0,    0, 1, 1);
        vecs[9]  = mk(0, 0, 1, 0, 0,    0, 1, 0);
        vecs[10] = mk(0, 1, 1, 1, 0,    0, 1, 0);
        vecs[11] = mk(0, 0, 1, 1, 0,   15, 0, 0);
        vecs[12] = mk(1, 1, 1, 0, 5,    0, 1, 0);
        vecs[13] = mk(0, 1, 0, 0, 1,    1, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 0,    0, 1, 1);
        vecs[15] = mk(0, 0, 0, 0, 0,    0, 1, 0);
        vecs[16] = mk(0, 1, 0, 0, 1,    1, 0, 0);
        vecs[17] = mk(0, 1, 1, 0, 0,    0, 1, 0);

        // reset held for two edges
        tick();
        tick();
        check("rst_cnt", 32'(bus_m.cnt), 32'd0);
        check("rst_tc", 32'(bus_m.cnt_tc), 32'd1);
        check("rst_pulse", 32'(bus_m.tc_pulse), 32'd0);
        check("rst_wraps", 32'(bus_m.wraps), 32'd0);

        // hold at zero
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        check("hold_zero_cnt", 32'(bus_m.cnt), 32'd0);
        check("hold_zero_wraps", 32'(bus_m.wraps), 32'd0);

        // table-driven vectors
        for (int i = 0; i < 18; i++) begin
            drive(int'(vecs[i].rst), int'(vecs[i].ld), int'(vecs[i].en),
                  int'(vecs[i].start), int'(vecs[i].ld_val));
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(bus_m.cnt), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_tc", i), 32'(bus_m.cnt_tc), 32'(vecs[i].tc));
            check($sformatf("vec%0d_pulse", i), 32'(bus_m.tc_pulse), 32'(vecs[i].pulse));
        end

        // load 1010 then count down; tally samples with cnt_tc low/high
        drive(0, 1, 0, 0, 10);
        tick();
        drive(0, 0, 1, 0, 0);
        r0 = 0; r1 = 0; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_m.cnt_tc) r1++; else r0++;
            if (bus_m.tc_pulse) pulses++;
            tick();
        end
        check("cnt_r0", 32'(r0), 32'd10);
        check("cnt_r1_first", 32'(r1), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (bus_m.cnt_tc) r1++; else r0++;
            if (bus_m.tc_pulse) pulses++;
            tick();
        end
        check("cnt_r1_total", 32'(r1), 32'd10);
        check("cnt_pulses", 32'(pulses), 32'd1);

        // wrap with start from zero: 17 edges
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 0);
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (bus_m.tc_pulse) pulses++;
        end
        check("wrap_cnt", 32'(bus_m.cnt), 32'd15);
        check("wrap_wraps", 32'(bus_m.wraps), 32'd2);
        check("wrap_pulses", 32'(pulses), 32'd1);

        // priority: load beats wrap, reset beats load
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 1, 3);
        tick();
        check("prio_ld_cnt", 32'(bus_m.cnt), 32'd3);
        check("prio_ld_wraps", 32'(bus_m.wraps), 32'd0);
        drive(1, 1, 1, 1, 9);
        tick();
        check("prio_rst_cnt", 32'(bus_m.cnt), 32'd0);

        // enable freeze, then reset mid-count at 0010
        drive(0, 1, 0, 0, 5);
        tick();
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        check("freeze_cnt", 32'(bus_m.cnt), 32'd5);
        check("freeze_pulse", 32'(bus_m.tc_pulse), 32'd0);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("midrst_pre", 32'(bus_m.cnt), 32'd2);
        drive(1, 0, 1, 0, 0);
        tick();
        check("midrst_cnt", 32'(bus_m.cnt), 32'd0);
        check("midrst_pulse", 32'(bus_m.tc_pulse), 32'd0);
        drive(0, 0, 1, 0, 0);
        tick();
        check("midrst_pulse_after", 32'(bus_m.tc_pulse), 32'd0);

        // saturation: 5*16 wrapping edges
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 80; i++) tick();
        check("sat_wraps2", 32'(bus_s.wraps), 32'd3);
        check("sat_wraps8", 32'(bus_m.wraps), 32'd5);
        check("sat_cnt", 32'(bus_s.cnt), 32'd0);
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 16; i++) tick();
        check("sat_hold", 32'(bus_s.wraps), 32'd3);

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, MAXC)));
            tick();
            check("rand_tc_known", 32'($isunknown(bus_m.cnt_tc)), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
